fc_argmax_5_9: RTL and testbench

//  Downstream classifier stage for an fc layer output stream.
//  - Consumes one output vector of M signed T-bit elements, serially, over a valid/ready stream.
//  - Emits the index and value of the largest element as one result beat.
//  - Sits directly after the fc_<M>_<N>_<T>_<R>_<P> layer; its input handshake connects to that layer's output_valid/output_ready/output_data.

---
 rtl/fc_argmax_5_9.sv | 138 +++++++++++++
 tb/tb_fc_argmax_5_9.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fc_argmax_5_9.sv
`default_nettype none
// ============================================================================
//  Module      : fc_argmax_5_9
//  Description : Argmax classifier stage for a serial fc-layer output stream.
//                Accepts M signed T-bit elements one per input handshake and
//                emits the position and value of the largest one as a single
//                result beat. Ties keep the lower index.
//  Ports       : clk          - rising-edge clock
//                reset        - asynchronous, active-low (0 = in reset)
//                input_valid  - upstream element valid
//                input_ready  - element accepted this cycle (state decode)
//                input_data   - signed element
//                output_valid - result beat valid (state decode)
//                output_ready - downstream accepts the result
//                output_index - position 0..M-1 of the maximum element
//                output_max   - signed value of the maximum element
//  Options     : FC_ARGMAX_RELU_EN - when defined, every accepted element is
//                clamped to zero if negative before compare and store.
//  Revision    : 1.0 - initial release
// ============================================================================
module fc_argmax_5_9 #(
    parameter  int M         = 5,
    parameter  int T         = 9,
    localparam int LOGSIZE_M = $clog2(M)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 input_valid,
    output logic                 input_ready,
    input  logic signed [T-1:0]  input_data,
    output logic                 output_valid,
    input  logic                 output_ready,
    output logic [LOGSIZE_M-1:0] output_index,
    output logic signed [T-1:0]  output_max
);

    localparam logic [LOGSIZE_M-1:0] c_LAST = LOGSIZE_M'(M - 1);

    typedef enum logic [0:0] {
        S_ACCUM = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [LOGSIZE_M-1:0]   r_count;
    logic [LOGSIZE_M-1:0]   r_index;
    logic signed [T-1:0]    r_max;

    logic                   w_accept;
    logic signed [T-1:0]    w_elem;
    logic                   w_take;
    logic signed [T-1:0]    w_new_max;
    logic [LOGSIZE_M-1:0]   w_new_index;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_ACCUM;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and handshake decode; both handshake outputs depend only on
    // the state register so there is no combinational input-to-output path.
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        input_ready  = 1'b0;
        output_valid = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            S_ACCUM: begin
                input_ready = 1'b1;
                w_accept    = input_valid;
                if (input_valid && (r_count == c_LAST)) begin
                    w_next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                output_valid = 1'b1;
                if (output_ready) begin
                    w_next_state = S_ACCUM;
                end
            end
            default: begin
                w_next_state = S_ACCUM;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Element conditioning and running-max compare
    // ------------------------------------------------------------------------
    always_comb begin
`ifdef FC_ARGMAX_RELU_EN
        w_elem = input_data[T-1] ? '0 : input_data;
`else
        w_elem = input_data;
`endif
        // The first element of a vector always seeds the running max; later
        // elements replace it only when strictly greater, so ties stay low.
        w_take      = (r_count == '0) || (w_elem > r_max);
        w_new_max   = w_take ? w_elem  : r_max;
        w_new_index = w_take ? r_count : r_index;
    end

    // ------------------------------------------------------------------------
    // Datapath registers. The result registers are loaded on the same edge
    // that accepts the last element, so they are already valid when the
    // state flips to HOLD and stay frozen until the next vector completes.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count      <= '0;
            r_index      <= '0;
            r_max        <= '0;
            output_index <= '0;
            output_max   <= '0;
        end else if (w_accept) begin
            r_max   <= w_new_max;
            r_index <= w_new_index;
            if (r_count == c_LAST) begin
                r_count      <= '0;
                output_max   <= w_new_max;
                output_index <= w_new_index;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fc_argmax_5_9.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fc_argmax_5_9
//  Description : Directed self-checking bench for fc_argmax_5_9 (M=5, T=9).
//                Inputs are driven 1 time unit after the rising edge and
//                outputs are sampled at the same point, away from the edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fc_argmax_5_9;

    localparam int M = 5;
    localparam int T = 9;
    localparam int LW = 3;

    logic                clk;
    logic                reset;
    logic                input_valid;
    logic                input_ready;
    logic signed [T-1:0] input_data;
    logic                output_valid;
    logic                output_ready;
    logic [LW-1:0]       output_index;
    logic signed [T-1:0] output_max;

    int n_vec;
    int n_err;

    fc_argmax_5_9 #(.M(M), .T(T)) dut (
        .clk          (clk),
        .reset        (reset),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .input_data   (input_data),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .output_index (output_index),
        .output_max   (output_max)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one element, wait (bounded) for it to be accepted, then drop valid.
    task automatic send_elem(input logic signed [T-1:0] d);
        bit done;
        done        = 1'b0;
        input_valid = 1'b1;
        input_data  = d;
        for (int i = 0; i < 30 && !done; i++) begin
            if (input_ready) done = 1'b1;
            step();
        end
        input_valid = 1'b0;
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: element %0d not accepted (input_ready=%0b, want 1)", d, input_ready);
        end
    endtask

    task automatic send_vec(input logic signed [T-1:0] v [5], input int max_gap);
        for (int i = 0; i < M; i++) begin
            int g;
            g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            for (int k = 0; k < g; k++) step();
            send_elem(v[i]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; input_valid = 1'b0; input_data = '0; output_ready = 1'b0;
        #3;
        n_vec++; if (input_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", input_ready); end
        n_vec++; if (output_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", output_valid); end
        n_vec++; if (output_index !== 3'd0) begin n_err++; $display("FAIL rst_index: got %0d want 0", output_index); end
        n_vec++; if (output_max !== 9'sd0) begin n_err++; $display("FAIL rst_max: got %0d want 0", output_max); end
        step(); step();
        reset = 1'b1;
        step();
        n_vec++; if (input_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_ready: got %b want 1", input_ready); end
    endtask

    task automatic test_basic();
        logic signed [T-1:0] v [5];
        v = '{9'sd3, -9'sd6, 9'sd1, 9'sd7, 9'sd2};
        output_ready = 1'b1;
        for (int i = 0; i < M - 1; i++) send_elem(v[i]);
        n_vec++; if (output_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid: got %b want 0", output_valid); end
        send_elem(v[M-1]);
        n_vec++; if (output_valid !== 1'b1) begin n_err++; $display("FAIL basic_latency: got %b want 1", output_valid); end
        n_vec++; if (input_ready !== 1'b0) begin n_err++; $display("FAIL basic_hold_ready: got %b want 0", input_ready); end
        n_vec++; if (output_index !== 3'd3) begin n_err++; $display("FAIL basic_index: got %0d want 3", output_index); end
        n_vec++; if (output_max !== 9'sd7) begin n_err++; $display("FAIL basic_max: got %0d want 7", output_max); end
        step();
        n_vec++; if (output_valid !== 1'b0) begin n_err++; $display("FAIL basic_xfer_valid: got %b want 0", output_valid); end
        n_vec++; if (input_ready !== 1'b1) begin n_err++; $display("FAIL basic_xfer_ready: got %b want 1", input_ready); end
    endtask

    task automatic test_ties();
        logic signed [T-1:0] v [5];
        v = '{9'sd4, 9'sd9, 9'sd9, -9'sd1, 9'sd9};
        output_ready = 1'b0;
        send_vec(v, 0);
        n_vec++; if (output_valid !== 1'b1) begin n_err++; $display("FAIL ties_valid: got %b want 1", output_valid); end
        n_vec++; if (output_index !== 3'd1) begin n_err++; $display("FAIL ties_index: got %0d want 1", output_index); end
        n_vec++; if (output_max !== 9'sd9) begin n_err++; $display("FAIL ties_max: got %0d want 9", output_max); end
        output_ready = 1'b1;
        step();
        output_ready = 1'b0;
    endtask

    task automatic test_negative();
        logic signed [T-1:0] v [5];
        logic [LW-1:0]       exp_idx;
        logic signed [T-1:0] exp_max;
        v = '{-9'sd3, -9'sd6, -9'sd1, -9'sd6, -9'sd256};
`ifdef FC_ARGMAX_RELU_EN
        exp_idx = 3'd0; exp_max = 9'sd0;
`else
        exp_idx = 3'd2; exp_max = -9'sd1;
`endif
        send_vec(v, 0);
        n_vec++; if (output_index !== exp_idx) begin n_err++; $display("FAIL neg_index: got %0d want %0d", output_index, exp_idx); end
        n_vec++; if (output_max !== exp_max) begin n_err++; $display("FAIL neg_max: got %0d want %0d", output_max, exp_max); end
        output_ready = 1'b1;
        step();
        output_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic signed [T-1:0] v [5];
        v = '{9'sd10, 9'sd20, -9'sd5, 9'sd30, 9'sd15};
        output_ready = 1'b0;
        send_vec(v, 0);
        // Offer a stray element during HOLD; it must not be taken.
        input_valid = 1'b1;
        input_data  = 9'sd200;
        for (int c = 0; c < 10; c++) begin
            n_vec++; if (output_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid c%0d: got %b want 1", c, output_valid); end
            n_vec++; if (input_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready c%0d: got %b want 0", c, input_ready); end
            n_vec++; if (output_index !== 3'd3) begin n_err++; $display("FAIL bp_index c%0d: got %0d want 3", c, output_index); end
            n_vec++; if (output_max !== 9'sd30) begin n_err++; $display("FAIL bp_max c%0d: got %0d want 30", c, output_max); end
            step();
        end
        input_valid  = 1'b0;
        output_ready = 1'b1;
        step();
        output_ready = 1'b0;
        n_vec++; if (output_valid !== 1'b0) begin n_err++; $display("FAIL bp_xfer_valid: got %b want 0", output_valid); end
        n_vec++; if (input_ready !== 1'b1) begin n_err++; $display("FAIL bp_xfer_ready: got %b want 1", input_ready); end
    endtask

    task automatic test_gaps();
        logic signed [T-1:0] v [5];
        v = '{-9'sd256, 9'sd255, 9'sd0, 9'sd0, 9'sd0};
        send_vec(v, 3);
        n_vec++; if (output_valid !== 1'b1) begin n_err++; $display("FAIL gaps_valid: got %b want 1", output_valid); end
        n_vec++; if (output_index !== 3'd1) begin n_err++; $display("FAIL gaps_index: got %0d want 1", output_index); end
        n_vec++; if (output_max !== 9'sd255) begin n_err++; $display("FAIL gaps_max: got %0d want 255", output_max); end
        output_ready = 1'b1;
        step();
        output_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic signed [T-1:0] big [5];
        logic signed [T-1:0] v [5];
        big = '{9'sd100, 9'sd90, 9'sd80, 9'sd70, 9'sd60};
        v   = '{9'sd1, 9'sd2, 9'sd3, 9'sd4, 9'sd5};
        // Reset while a result is pending in HOLD.
        send_vec(big, 0);
        n_vec++; if (output_valid !== 1'b1) begin n_err++; $display("FAIL rmid_pre_valid: got %b want 1", output_valid); end
        #2 reset = 1'b0;
        #1;
        n_vec++; if (output_valid !== 1'b0) begin n_err++; $display("FAIL rmid_hold_valid: got %b want 0", output_valid); end
        n_vec++; if (input_ready !== 1'b1) begin n_err++; $display("FAIL rmid_hold_ready: got %b want 1", input_ready); end
        n_vec++; if (output_max !== 9'sd0) begin n_err++; $display("FAIL rmid_hold_max: got %0d want 0", output_max); end
        step();
        reset = 1'b1;
        step();
        // Reset after three accepted elements of a vector.
        for (int i = 0; i < 3; i++) send_elem(big[i]);
        #2 reset = 1'b0;
        #1;
        n_vec++; if (output_valid !== 1'b0) begin n_err++; $display("FAIL rmid_part_valid: got %b want 0", output_valid); end
        step();
        reset = 1'b1;
        step();
        for (int i = 0; i < M - 1; i++) send_elem(v[i]);
        n_vec++; if (output_valid !== 1'b0) begin n_err++; $display("FAIL rmid_early_valid: got %b want 0", output_valid); end
        send_elem(v[M-1]);
        n_vec++; if (output_valid !== 1'b1) begin n_err++; $display("FAIL rmid_valid: got %b want 1", output_valid); end
        n_vec++; if (output_index !== 3'd4) begin n_err++; $display("FAIL rmid_index: got %0d want 4", output_index); end
        n_vec++; if (output_max !== 9'sd5) begin n_err++; $display("FAIL rmid_max: got %0d want 5", output_max); end
        output_ready = 1'b1;
        step();
        output_ready = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_ties();
        test_negative();
        test_backpressure();
        test_gaps();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
